mmc3_sync: RTL and testbench

MMC3_SYNC -- requirements
Module: mmc3_sync

---
 rtl/mmc3_sync.sv | 198 +++++++++++++++++++
 tb/tb_mmc3_sync.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmc3_sync.sv
// MMC3-style mapper running on a fast system clock: CPU/PPU strobes are synchronised,
// register writes commit on the M2 falling edge, and the scanline IRQ counter is clocked by filtered PPU A12.
module mmc3_sync #(
   parameter int PRG_BANK_W  = 6,
   parameter int CHR_BANK_W  = 8,
   parameter int USE_CHR_RAM = 1,
   parameter int A12_FILTER  = 3,
   parameter int IRQ_MODE    = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  m2,
   input  logic                  romsel,
   input  logic                  cpu_rw_in,
   input  logic [14:0]           cpu_addr_in,
   input  logic [7:0]            cpu_data_in,
   output logic [PRG_BANK_W:0]   cpu_addr_out,
   output logic                  cpu_wr_out,
   output logic                  cpu_rd_out,
   output logic                  cpu_flash_ce,
   output logic                  cpu_sram_ce,
   input  logic                  ppu_rd_in,
   input  logic                  ppu_wr_in,
   input  logic [3:0]            ppu_addr_in,
   output logic [CHR_BANK_W-1:0] ppu_addr_out,
   output logic                  ppu_rd_out,
   output logic                  ppu_wr_out,
   output logic                  ppu_flash_ce,
   output logic                  ppu_sram_ce,
   output logic                  ppu_ciram_a10,
   output logic                  ppu_ciram_ce,
   output logic                  irq
);

   localparam logic [2:0]            FILT       = 3'(A12_FILTER);
   localparam logic [PRG_BANK_W-1:0] PRG_LAST   = '1;
   localparam logic [PRG_BANK_W-1:0] PRG_SECOND = PRG_LAST - 1'b1;

   logic       r_m2_s1, r_m2_s2, r_m2_d;
   logic       r_rs_s1, r_rs_s2;
   logic       r_rw_s1, r_rw_s2;
   logic       r_a12_s1, r_a12_s2, r_a12_d;
   logic [2:0] r_cmd;
   logic [7:0] r_data;
   logic [2:0] r_bank_sel;
   logic       r_prg_mode, r_chr_mode, r_mirror;
   logic [1:0] r_ram_prot;
   logic [7:0] r_bank [8];
   logic [7:0] r_irq_latch, r_counter;
   logic       r_reload, r_irq_en, r_pending;
   logic [2:0] r_low_cnt;

   logic       w_m2_fall, w_commit, w_a12_rise, w_cnt_clk;
   logic [7:0] w_ctr_next;
   logic       w_reload_next, w_pend_set;
   logic [PRG_BANK_W-1:0] w_prg_bank;
   logic [7:0] w_chr_full;
   logic       w_unused;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {r_m2_s1, r_m2_s2, r_m2_d}     <= '0;
         {r_rs_s1, r_rs_s2}             <= '0;
         {r_rw_s1, r_rw_s2}             <= '0;
         {r_a12_s1, r_a12_s2, r_a12_d}  <= '0;
      end else begin
         {r_m2_s1, r_m2_s2, r_m2_d}     <= {m2, r_m2_s1, r_m2_s2};
         {r_rs_s1, r_rs_s2}             <= {romsel, r_rs_s1};
         {r_rw_s1, r_rw_s2}             <= {cpu_rw_in, r_rw_s1};
         {r_a12_s1, r_a12_s2, r_a12_d}  <= {ppu_addr_in[2], r_a12_s1, r_a12_s2};
      end
   end

   // Bus capture is pure data: only the decode bits of the address are kept.
   always_ff @(posedge clk) begin
      if (r_m2_s2) begin
         r_cmd  <= {cpu_addr_in[14], cpu_addr_in[13], cpu_addr_in[0]};
         r_data <= cpu_data_in;
      end
   end

   assign w_m2_fall  = r_m2_d & ~r_m2_s2;
   assign w_commit   = w_m2_fall & ~r_rs_s2 & ~r_rw_s2;
   assign w_a12_rise = r_a12_s2 & ~r_a12_d;
   assign w_cnt_clk  = w_a12_rise & (r_low_cnt == FILT);

   // Counter clock sees the old state; a same-cycle $C001 then overrides it.
   always_comb begin
      w_ctr_next    = r_counter;
      w_reload_next = r_reload;
      w_pend_set    = 1'b0;
      if (w_cnt_clk) begin
         if (r_counter == 8'd0 || r_reload) begin
            w_ctr_next    = r_irq_latch;
            w_reload_next = 1'b0;
         end else begin
            w_ctr_next = r_counter - 8'd1;
         end
         if (IRQ_MODE == 0)
            w_pend_set = r_irq_en && (w_ctr_next == 8'd0);
         else
            w_pend_set = r_irq_en && ((r_counter == 8'd1 && !r_reload) ||
                                      (r_reload && r_irq_latch == 8'd0));
      end
      if (w_commit && r_cmd == 3'b101) begin
         w_ctr_next    = 8'd0;
         w_reload_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bank_sel  <= 3'd0;
         r_prg_mode  <= 1'b0;
         r_chr_mode  <= 1'b0;
         r_mirror    <= 1'b0;
         r_ram_prot  <= 2'b00;
         r_bank[0]   <= 8'd0;
         r_bank[1]   <= 8'd2;
         r_bank[2]   <= 8'd4;
         r_bank[3]   <= 8'd5;
         r_bank[4]   <= 8'd6;
         r_bank[5]   <= 8'd7;
         r_bank[6]   <= 8'd0;
         r_bank[7]   <= 8'd1;
         r_irq_latch <= 8'd0;
         r_counter   <= 8'd0;
         r_reload    <= 1'b0;
         r_irq_en    <= 1'b0;
         r_pending   <= 1'b0;
      end else begin
         if (w_commit) begin
            case (r_cmd)
               3'b000: begin
                  r_bank_sel <= r_data[2:0];
                  r_prg_mode <= r_data[6];
                  r_chr_mode <= r_data[7];
               end
               3'b001:  r_bank[r_bank_sel] <= r_data;
               3'b010:  r_mirror    <= r_data[0];
               3'b011:  r_ram_prot  <= r_data[7:6];
               3'b100:  r_irq_latch <= r_data;
               3'b110:  r_irq_en    <= 1'b0;
               3'b111:  r_irq_en    <= 1'b1;
               default: ;
            endcase
         end
         r_counter <= w_ctr_next;
         r_reload  <= w_reload_next;
         if (w_commit && r_cmd == 3'b110)
            r_pending <= 1'b0;
         else if (w_pend_set)
            r_pending <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_low_cnt <= 3'd0;
      else if (r_a12_s2)
         r_low_cnt <= 3'd0;
      else if (w_m2_fall && r_low_cnt != FILT)
         r_low_cnt <= r_low_cnt + 3'd1;
   end

   always_comb begin
      case (cpu_addr_in[14:13])
         2'b00:   w_prg_bank = r_prg_mode ? PRG_SECOND : r_bank[6][PRG_BANK_W-1:0];
         2'b01:   w_prg_bank = r_bank[7][PRG_BANK_W-1:0];
         2'b10:   w_prg_bank = r_prg_mode ? r_bank[6][PRG_BANK_W-1:0] : PRG_SECOND;
         default: w_prg_bank = PRG_LAST;
      endcase
   end

   // 2 KiB windows sit on the A12 half selected by chr_mode; the other half uses r2..r5.
   always_comb begin
      if (ppu_addr_in[2] == r_chr_mode)
         w_chr_full = {r_bank[{2'b00, ppu_addr_in[1]}][7:1], ppu_addr_in[0]};
      else
         w_chr_full = r_bank[3'd2 + {1'b0, ppu_addr_in[1:0]}];
   end

   assign cpu_addr_out  = {w_prg_bank, cpu_addr_in[12]};
   assign ppu_addr_out  = w_chr_full[CHR_BANK_W-1:0];
   assign ppu_rd_out    = ppu_rd_in;
   assign ppu_wr_out    = ppu_wr_in;
   assign ppu_ciram_a10 = r_mirror ? ppu_addr_in[1] : ppu_addr_in[0];
   assign ppu_ciram_ce  = ~ppu_addr_in[3];
   assign ppu_sram_ce   = (USE_CHR_RAM != 0) ? ppu_addr_in[3] : 1'b1;
   assign ppu_flash_ce  = (USE_CHR_RAM != 0) ? 1'b1 : ppu_addr_in[3];
   assign cpu_sram_ce   = ~(cpu_addr_in[14] & cpu_addr_in[13] & m2 & romsel & r_ram_prot[1]);
   assign cpu_wr_out    = cpu_rw_in | r_ram_prot[0] | ~r_ram_prot[1];
   assign cpu_flash_ce  = romsel;
   assign cpu_rd_out    = ~cpu_rw_in;
   assign irq           = r_pending ? 1'b0 : 1'bz;
   assign w_unused      = ^{cpu_addr_in[11:1], w_chr_full, r_bank[6], r_bank[7], r_bank[0], r_bank[1]};

endmodule

// File: tb/tb_mmc3_sync.sv
// Directed bench for mmc3_sync: a default-parameter instance and a 4-bit PRG / CHR ROM /
// edge-IRQ instance driven from the same bus, with the open-drain IRQ lines pulled up.
module tb_mmc3_sync;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m2, romsel, cpu_rw_in;
   logic [14:0] cpu_addr_in;
   logic [7:0]  cpu_data_in;
   logic        ppu_rd_in, ppu_wr_in;
   logic [3:0]  ppu_addr_in;

   logic [6:0]  cpu_addr_out0;
   logic [4:0]  cpu_addr_out1;
   logic        cpu_wr_out0, cpu_rd_out0, cpu_flash_ce0, cpu_sram_ce0;
   logic        cpu_wr_out1, cpu_rd_out1, cpu_flash_ce1, cpu_sram_ce1;
   logic [7:0]  ppu_addr_out0;
   logic [4:0]  ppu_addr_out1;
   logic        ppu_rd_out0, ppu_wr_out0, ppu_flash_ce0, ppu_sram_ce0, ppu_ciram_a10_0, ppu_ciram_ce0;
   logic        ppu_rd_out1, ppu_wr_out1, ppu_flash_ce1, ppu_sram_ce1, ppu_ciram_a10_1, ppu_ciram_ce1;
   wire         irq0, irq1;
   pullup (irq0);
   pullup (irq1);

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mmc3_sync u_dut0 (
      .clk(clk), .rst_n(rst_n), .m2(m2), .romsel(romsel), .cpu_rw_in(cpu_rw_in),
      .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in), .cpu_addr_out(cpu_addr_out0),
      .cpu_wr_out(cpu_wr_out0), .cpu_rd_out(cpu_rd_out0), .cpu_flash_ce(cpu_flash_ce0),
      .cpu_sram_ce(cpu_sram_ce0), .ppu_rd_in(ppu_rd_in), .ppu_wr_in(ppu_wr_in),
      .ppu_addr_in(ppu_addr_in), .ppu_addr_out(ppu_addr_out0), .ppu_rd_out(ppu_rd_out0),
      .ppu_wr_out(ppu_wr_out0), .ppu_flash_ce(ppu_flash_ce0), .ppu_sram_ce(ppu_sram_ce0),
      .ppu_ciram_a10(ppu_ciram_a10_0), .ppu_ciram_ce(ppu_ciram_ce0), .irq(irq0)
   );

   mmc3_sync #(
      .PRG_BANK_W(4), .CHR_BANK_W(5), .USE_CHR_RAM(0), .A12_FILTER(3), .IRQ_MODE(1)
   ) u_dut1 (
      .clk(clk), .rst_n(rst_n), .m2(m2), .romsel(romsel), .cpu_rw_in(cpu_rw_in),
      .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in), .cpu_addr_out(cpu_addr_out1),
      .cpu_wr_out(cpu_wr_out1), .cpu_rd_out(cpu_rd_out1), .cpu_flash_ce(cpu_flash_ce1),
      .cpu_sram_ce(cpu_sram_ce1), .ppu_rd_in(ppu_rd_in), .ppu_wr_in(ppu_wr_in),
      .ppu_addr_in(ppu_addr_in), .ppu_addr_out(ppu_addr_out1), .ppu_rd_out(ppu_rd_out1),
      .ppu_wr_out(ppu_wr_out1), .ppu_flash_ce(ppu_flash_ce1), .ppu_sram_ce(ppu_sram_ce1),
      .ppu_ciram_a10(ppu_ciram_a10_1), .ppu_ciram_ce(ppu_ciram_ce1), .irq(irq1)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      cpu_addr_in = a[14:0]; cpu_data_in = d; romsel = ~a[15]; cpu_rw_in = 1'b0; m2 = 1'b1;
      repeat (6) @(negedge clk);
      m2 = 1'b0;
      repeat (6) @(negedge clk);
      romsel = 1'b1; cpu_rw_in = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic prg_chk(input string tag, input logic [15:0] a, input logic [6:0] e0, input logic [4:0] e1);
      @(negedge clk);
      cpu_addr_in = a[14:0]; romsel = ~a[15]; cpu_rw_in = 1'b1;
      #1;
      chk({tag, "_d0"}, 16'(cpu_addr_out0), 16'(e0));
      chk({tag, "_d1"}, 16'(cpu_addr_out1), 16'(e1));
      romsel = 1'b1;
   endtask

   task automatic chr_chk(input string tag, input logic [3:0] pa, input logic [7:0] e0, input logic [4:0] e1);
      @(negedge clk);
      ppu_addr_in = pa;
      #1;
      chk({tag, "_d0"}, 16'(ppu_addr_out0), 16'(e0));
      chk({tag, "_d1"}, 16'(ppu_addr_out1), 16'(e1));
   endtask

   task automatic m2_cycle();
      @(negedge clk);
      m2 = 1'b1;
      repeat (4) @(negedge clk);
      m2 = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic a12_pulse();
      @(negedge clk);
      ppu_addr_in = 4'b0100;
      repeat (6) @(negedge clk);
      ppu_addr_in = 4'b0000;
      repeat (4) @(negedge clk);
   endtask

   task automatic rise();
      repeat (3) m2_cycle();
      a12_pulse();
   endtask

   task automatic irq_chk(input string tag, input logic e0, input logic e1);
      #1;
      chk({tag, "_irq0"}, 16'(irq0), 16'(e0));
      chk({tag, "_irq1"}, 16'(irq1), 16'(e1));
   endtask

   initial begin
      rst_n = 1'b0; m2 = 1'b0; romsel = 1'b1; cpu_rw_in = 1'b1;
      cpu_addr_in = '0; cpu_data_in = '0; ppu_rd_in = 1'b1; ppu_wr_in = 1'b1; ppu_addr_in = '0;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Reset-state mapping and IRQ released
      irq_chk("rst", 1'b1, 1'b1);
      prg_chk("rst_e000", 16'hE000, 7'h7E, 5'h1E);
      prg_chk("rst_f000", 16'hF000, 7'h7F, 5'h1F);
      prg_chk("rst_8000", 16'h8000, 7'h00, 5'h00);
      prg_chk("rst_a000", 16'hA000, 7'h02, 5'h02);
      prg_chk("rst_c000", 16'hC000, 7'h7C, 5'h1C);
      chr_chk("rst_chr0", 4'b0000, 8'h00, 5'h00);
      chr_chk("rst_chr3", 4'b0011, 8'h03, 5'h03);
      chr_chk("rst_chr4", 4'b0100, 8'h04, 5'h04);
      chr_chk("rst_chr7", 4'b0111, 8'h07, 5'h07);

      // PRG mode swap and bank registers
      cpu_write(16'h8000, 8'h40);
      prg_chk("pm1_8000", 16'h8000, 7'h7C, 5'h1C);
      prg_chk("pm1_c000", 16'hC000, 7'h00, 5'h00);
      cpu_write(16'h8000, 8'h06);
      cpu_write(16'h8001, 8'h05);
      prg_chk("r6_5", 16'h8000, 7'h0A, 5'h0A);
      cpu_write(16'h8001, 8'hFF);
      prg_chk("r6_ff", 16'h8000, 7'h7E, 5'h1E);
      cpu_write(16'h8000, 8'h07);
      cpu_write(16'h8001, 8'h09);
      prg_chk("r7_9", 16'hA000, 7'h12, 5'h12);

      // CHR mode swap and truncation
      cpu_write(16'h8000, 8'h80);
      chr_chk("cm1_hi", 4'b0100, 8'h00, 5'h00);
      chr_chk("cm1_lo", 4'b0000, 8'h04, 5'h04);
      cpu_write(16'h8000, 8'h82);
      cpu_write(16'h8001, 8'h33);
      chr_chk("r2_33", 4'b0000, 8'h33, 5'h13);
      chr_chk("r3_5", 4'b0001, 8'h05, 5'h05);

      // Mirroring, CIRAM and CHR chip enables, PPU strobes
      chr_chk("mir0_a10", 4'b0001, 8'h05, 5'h05);
      chk("mir0_ciram", 16'(ppu_ciram_a10_0), 16'h1);
      cpu_write(16'hA000, 8'h01);
      @(negedge clk); ppu_addr_in = 4'b0010; ppu_rd_in = 1'b0; #1;
      chk("mir1_ciram0", 16'(ppu_ciram_a10_0), 16'h1);
      chk("mir1_ciram1", 16'(ppu_ciram_a10_1), 16'h1);
      chk("ppu_rd", 16'({ppu_rd_out0, ppu_rd_out1, ppu_wr_out0}), 16'h1);
      chk("ce_lo", 16'({ppu_sram_ce0, ppu_flash_ce0, ppu_sram_ce1, ppu_flash_ce1, ppu_ciram_ce0}), 16'b01101);
      @(negedge clk); ppu_addr_in = 4'b1000; ppu_rd_in = 1'b1; #1;
      chk("ce_hi", 16'({ppu_sram_ce0, ppu_flash_ce0, ppu_sram_ce1, ppu_flash_ce1, ppu_ciram_ce0}), 16'b11110);
      @(negedge clk); ppu_addr_in = 4'b0000;

      // PRG RAM enables and write protect
      @(negedge clk); cpu_addr_in = 15'h6000; romsel = 1'b1; cpu_rw_in = 1'b0; m2 = 1'b1; #1;
      chk("ram_off", 16'({cpu_sram_ce0, cpu_wr_out0, cpu_flash_ce0, cpu_rd_out0}), 16'b1111);
      m2 = 1'b0; cpu_rw_in = 1'b1;
      repeat (4) @(negedge clk);
      cpu_write(16'hA001, 8'h80);
      @(negedge clk); cpu_addr_in = 15'h6000; romsel = 1'b1; cpu_rw_in = 1'b1; m2 = 1'b1; #1;
      chk("ram_rd", 16'({cpu_sram_ce0, cpu_wr_out0, cpu_sram_ce1, cpu_rd_out0}), 16'b0100);
      cpu_rw_in = 1'b0; #1;
      chk("ram_wr", 16'({cpu_sram_ce0, cpu_wr_out0, cpu_rd_out0}), 16'b001);
      m2 = 1'b0; cpu_rw_in = 1'b1; #1;
      chk("ram_m2lo", 16'(cpu_sram_ce0), 16'h1);
      repeat (4) @(negedge clk);
      cpu_write(16'hA001, 8'hC0);
      @(negedge clk); cpu_addr_in = 15'h6000; romsel = 1'b1; cpu_rw_in = 1'b0; m2 = 1'b1; #1;
      chk("ram_wp", 16'({cpu_sram_ce0, cpu_wr_out0}), 16'b01);
      m2 = 1'b0; cpu_rw_in = 1'b1;
      repeat (4) @(negedge clk);

      // IRQ latch=3: fires on the 4th filtered rise and again 4 rises later
      cpu_write(16'hC000, 8'h03);
      cpu_write(16'hC001, 8'h00);
      cpu_write(16'hE001, 8'h00);
      rise(); irq_chk("l3_r1", 1'b1, 1'b1);
      rise(); irq_chk("l3_r2", 1'b1, 1'b1);
      rise(); irq_chk("l3_r3", 1'b1, 1'b1);
      rise(); irq_chk("l3_r4", 1'b0, 1'b0);
      cpu_write(16'hE001, 8'h00);
      irq_chk("e001_keeps", 1'b0, 1'b0);
      cpu_write(16'hE000, 8'h00);
      irq_chk("e000_clr", 1'b1, 1'b1);
      cpu_write(16'hE001, 8'h00);
      rise(); irq_chk("l3_r5", 1'b1, 1'b1);
      rise(); irq_chk("l3_r6", 1'b1, 1'b1);
      rise(); irq_chk("l3_r7", 1'b1, 1'b1);
      rise(); irq_chk("l3_r8", 1'b0, 1'b0);

      // Latch=0: repeat mode fires every rise, edge mode only after $C001
      cpu_write(16'hE000, 8'h00);
      cpu_write(16'hC000, 8'h00);
      cpu_write(16'hC001, 8'h00);
      cpu_write(16'hE001, 8'h00);
      rise(); irq_chk("l0_r1", 1'b0, 1'b0);
      cpu_write(16'hE000, 8'h00);
      cpu_write(16'hE001, 8'h00);
      rise(); irq_chk("l0_r2", 1'b0, 1'b1);
      cpu_write(16'hE000, 8'h00);
      cpu_write(16'hE001, 8'h00);
      rise(); irq_chk("l0_r3", 1'b0, 1'b1);

      // A12 filter: rises with only two M2 lows do not clock the counter
      cpu_write(16'hE000, 8'h00);
      cpu_write(16'hC000, 8'h01);
      cpu_write(16'hC001, 8'h00);
      cpu_write(16'hE001, 8'h00);
      rise(); irq_chk("flt_load", 1'b1, 1'b1);
      repeat (2) m2_cycle(); a12_pulse(); irq_chk("flt_short1", 1'b1, 1'b1);
      repeat (2) m2_cycle(); a12_pulse(); irq_chk("flt_short2", 1'b1, 1'b1);
      rise(); irq_chk("flt_full", 1'b0, 1'b0);

      // $E000 commit in the same clk as a pending-set: disable wins
      cpu_write(16'hE000, 8'h00);
      cpu_write(16'hC000, 8'h00);
      cpu_write(16'hC001, 8'h00);
      cpu_write(16'hE001, 8'h00);
      repeat (3) m2_cycle();
      @(negedge clk);
      cpu_addr_in = 15'h6000; cpu_data_in = 8'h00; romsel = 1'b0; cpu_rw_in = 1'b0; m2 = 1'b1;
      repeat (6) @(negedge clk);
      m2 = 1'b0; ppu_addr_in = 4'b0100;
      repeat (6) @(negedge clk);
      ppu_addr_in = 4'b0000; romsel = 1'b1; cpu_rw_in = 1'b1;
      repeat (4) @(negedge clk);
      irq_chk("e000_wins", 1'b1, 1'b1);
      cpu_write(16'hE001, 8'h00);
      rise(); irq_chk("after_tie", 1'b0, 1'b1);

      // Reset just after an M2 fall aborts the in-flight mirroring write
      @(negedge clk);
      cpu_addr_in = 15'h2000; cpu_data_in = 8'h00; romsel = 1'b0; cpu_rw_in = 1'b0; m2 = 1'b1;
      repeat (6) @(negedge clk);
      cpu_data_in = 8'h01;
      repeat (2) @(negedge clk);
      m2 = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      romsel = 1'b1; cpu_rw_in = 1'b1;
      repeat (2) @(negedge clk);
      irq_chk("rst_mid", 1'b1, 1'b1);
      ppu_addr_in = 4'b0010; #1;
      chk("rst_abort_mir", 16'({ppu_ciram_a10_0, ppu_ciram_a10_1}), 16'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
